pipelined_shifter: RTL
======================

// Module: pipelined_shifter
// PURPOSE
//  Parametrised, pipelined barrel shifter for the EX stage: logical left, logical right,
//  arithmetic right and (optional) rotate-right. Log-depth mux levels are split across
//  STAGES register stages with a valid/ready elastic handshake, flush and zero flag.
// PARAMETERS
//  WIDTH    32               operand width; power of two, 8..64
//  SHAMT_W  $clog2(WIDTH)    shift-amount width (derived, do not override)
//  STAGES   2                register stages, 1..SHAMT_W; latency in cycles
// PORTS
//  clk        in   1        clock, all state on rising edge
//  rst        in   1        synchronous, active-high reset
//  flush      in   1        synchronous pipeline kill (branch mispredict)
//  in_valid   in   1        input beat valid
//  in_ready   out  1        block can accept a beat this cycle
//  in_op      in   2        shift_op_t: 00 SLL, 01 SRL, 10 SRA, 11 ROTR
//  in_data    in   WIDTH    operand
//  in_shamt   in   SHAMT_W  shift amount, unsigned, 0..WIDTH-1
//  out_valid  out  1        result beat valid
//  out_ready  in   1        consumer accepts result
//  out_data   out  WIDTH    result
//  out_zero   out  1        out_data == 0
// BEHAVIOUR
//  - Levels: level k shifts by 2^k when shamt bit k set, k = 0..SHAMT_W-1 (LSB level first).
//  - Level-to-stage split: stage s holds levels ceil(s*SHAMT_W/STAGES)..ceil((s+1)*SHAMT_W/STAGES)-1.
//  - Each stage registers valid, op, remaining shamt bits, partial data; latency = STAGES cycles.
//  - SLL fills 0 at LSB; SRL fills 0 at MSB; SRA fills in_data MSB; ROTR wraps LSBs to MSBs.
//  - shamt 0: out_data == in_data for every op.
//  - Handshake: transfer on valid&&ready. Stage s advances when !valid_s or stage s+1 advances;
//    last stage advances when out_ready. in_ready = stage-0 advance condition (combinational
//    from out_ready through the chain; accepted). Full throughput 1 beat/cycle.
//  - Stall: out_valid && !out_ready holds out_data/out_zero stable; no beat dropped or duplicated.
//  - out_valid must not drop without a transfer, except on flush/rst.
//  - flush: all stage valids cleared next cycle; in_valid beat in same cycle is discarded;
//    in_ready forced 0 during flush. flush and rst together behave as rst.
//  - Reset: all valids 0, out_valid 0, out_data 0, out_zero 1, in_ready 1 from first post-reset cycle.
//  - Data/op registers need no reset; only valid bits do (out_data masked to 0 while !out_valid).
// CONFIGURATION
//  - SHIFTER_ROTATE_EN defined: op 11 = rotate right by shamt.
//  - Not defined: rotate logic absent; op 11 executes as SLL; no other behaviour changes.
// STRUCTURE
//  - shifter_pkg: typedef enum logic [1:0] shift_op_t {SH_SLL, SH_SRL, SH_SRA, SH_ROTR};
//    function for level-to-stage bounds; localparam default WIDTH.
//  - Sub-module shift_stage (params WIDTH, FIRST_LVL, NUM_LVL): combinational levels plus
//    valid/data/op/shamt register and local advance logic; instantiated STAGES times in a generate.
// TESTING
//  - Reset: rst 2 cycles -> out_valid 0, out_data 0, out_zero 1, in_ready 1.
//  - SLL 0x0000_0001 by 31 -> 0x8000_0000 after 2 cycles; SRL 0x8000_0000 by 4 -> 0x0800_0000.
//  - SRA 0xF000_0000 by 8 -> 0xFFF0_0000; SRA 0x7000_0000 by 8 -> 0x0070_0000; SLL x by 0 -> x.
//  - ROTR 0x0000_00F1 by 4 -> 0x1000_000F (macro on); same beat with macro off -> 0x0000_0F10.
//  - Back-to-back 100 random beats, random out_ready deassertion -> in-order, match model, no loss.
//  - flush with 2 beats in flight and in_valid high -> no out_valid for those beats; next beat correct.

Source files
------------

// File: rtl/shifter_pkg.sv
// Shared types and helpers for the pipelined barrel shifter.
// Level k of the shifter moves data by 2^k; stage_first_lvl() splits the levels across pipeline stages.
package shifter_pkg;

   localparam int DEF_WIDTH = 32;

   typedef enum logic [1:0] {
      SH_SLL  = 2'b00,
      SH_SRL  = 2'b01,
      SH_SRA  = 2'b10,
      SH_ROTR = 2'b11
   } shift_op_t;

   // The first level handled by stage s is ceil(s*shamt_w/stages).
   function automatic int stage_first_lvl(input int s, input int shamt_w, input int stages);
      return (s * shamt_w + stages - 1) / stages;
   endfunction

endpackage

// File: rtl/shift_stage.sv
// One pipeline stage: applies NUM_LVL mux levels starting at FIRST_LVL, then registers the result.
// Latency is 1 cycle. The stage holds its contents while it is valid and the downstream stage does not advance.
module shift_stage
   import shifter_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int SHAMT_W   = $clog2(WIDTH),
   parameter int FIRST_LVL = 0,
   parameter int NUM_LVL   = 1
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_flush,
   input  logic               i_vld,
   input  shift_op_t          i_op,
   input  logic [WIDTH-1:0]   i_dat,
   input  logic [SHAMT_W-1:0] i_shamt,
   input  logic               i_nxt_adv,
   output logic               o_adv,
   output logic               o_vld,
   output shift_op_t          o_op,
   output logic [WIDTH-1:0]   o_dat,
   output logic [SHAMT_W-1:0] o_shamt
);

   logic               r_vld;
   shift_op_t          r_op;
   logic [WIDTH-1:0]   r_dat;
   logic [SHAMT_W-1:0] r_shamt;
   logic [WIDTH-1:0]   w_dat;

   // SRA relies on the partial result keeping the original sign in its MSB.
   function automatic logic [WIDTH-1:0] lvl_shift(input logic [WIDTH-1:0] d,
                                                  input shift_op_t op, input int amt);
      logic [WIDTH-1:0] r;
      case (op)
         SH_SRL:  r = d >> amt;
         SH_SRA:  r = $signed(d) >>> amt;
`ifdef SHIFTER_ROTATE_EN
         SH_ROTR: r = (d >> amt) | (d << (WIDTH - amt));
`endif
         default: r = d << amt;
      endcase
      return r;
   endfunction

   always_comb begin
      w_dat = i_dat;
      for (int k = 0; k < NUM_LVL; k++) begin
         if ((i_shamt & (SHAMT_W'(1) << (FIRST_LVL + k))) != '0)
            w_dat = lvl_shift(w_dat, i_op, 1 << (FIRST_LVL + k));
      end
   end

   assign o_adv = !r_vld || i_nxt_adv;

   always_ff @(posedge i_clk) begin
      if (i_rst || i_flush)
         r_vld <= 1'b0;
      else if (o_adv)
         r_vld <= i_vld;
   end

   always_ff @(posedge i_clk) begin
      if (o_adv && i_vld) begin
         r_dat   <= w_dat;
         r_op    <= i_op;
         r_shamt <= i_shamt;
      end
   end

   assign o_vld   = r_vld;
   assign o_op    = r_op;
   assign o_dat   = r_dat;
   assign o_shamt = r_shamt;

endmodule

// File: rtl/pipelined_shifter.sv
// Pipelined SLL/SRL/SRA barrel shifter; rotate-right on op 11 when SHIFTER_ROTATE_EN is defined, else op 11 acts as SLL.
// Latency is STAGES cycles at one beat per cycle. in_ready ripples back from out_ready and is held low during flush.
module pipelined_shifter
   import shifter_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int SHAMT_W = $clog2(WIDTH),
   parameter int STAGES  = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [1:0]         in_op,
   input  logic [WIDTH-1:0]   in_data,
   input  logic [SHAMT_W-1:0] in_shamt,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_data,
   output logic               out_zero
);

   logic               w_vld   [0:STAGES];
   logic               w_adv   [0:STAGES];
   shift_op_t          w_op    [0:STAGES];
   logic [WIDTH-1:0]   w_dat   [0:STAGES];
   logic [SHAMT_W-1:0] w_shamt [0:STAGES];
   logic               w_unused_tail;

   // A beat offered during flush never enters the pipe.
   assign w_vld[0]   = in_valid && !flush;
   assign w_op[0]    = shift_op_t'(in_op);
   assign w_dat[0]   = in_data;
   assign w_shamt[0] = in_shamt;
   assign w_adv[STAGES] = out_ready;

   genvar s;
   generate
      for (s = 0; s < STAGES; s++) begin : g_stage
         localparam int FL = stage_first_lvl(s, SHAMT_W, STAGES);
         localparam int NL = stage_first_lvl(s + 1, SHAMT_W, STAGES) - FL;

         shift_stage #(
            .WIDTH     (WIDTH),
            .SHAMT_W   (SHAMT_W),
            .FIRST_LVL (FL),
            .NUM_LVL   (NL)
         ) u_stage (
            .i_clk     (clk),
            .i_rst     (rst),
            .i_flush   (flush),
            .i_vld     (w_vld[s]),
            .i_op      (w_op[s]),
            .i_dat     (w_dat[s]),
            .i_shamt   (w_shamt[s]),
            .i_nxt_adv (w_adv[s+1]),
            .o_adv     (w_adv[s]),
            .o_vld     (w_vld[s+1]),
            .o_op      (w_op[s+1]),
            .o_dat     (w_dat[s+1]),
            .o_shamt   (w_shamt[s+1])
         );
      end
   endgenerate

   assign in_ready  = w_adv[0] && !flush;
   assign out_valid = w_vld[STAGES];
   // Data registers are never reset, so the result is masked while the output is idle.
   assign out_data  = out_valid ? w_dat[STAGES] : '0;
   assign out_zero  = (out_data == '0);

   assign w_unused_tail = ^{w_op[STAGES], w_shamt[STAGES]};

endmodule
